// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared definitions for the split_hash parser.
//   - parser state enum
//   - field lengths of the 60-character "$2b$NN$<salt22><hash31>" string
//   - ASCII constants used by the header/cost/separator checks and decoder
//   - bit widths of the decoded fields and their accumulators
package bcrypt_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_COST, S_SEP, S_SALT, S_HASH, S_DONE, S_ERR
   } state_t;

   localparam int CNT_W = 6;
   localparam int R64_W = 6;

   localparam logic [CNT_W-1:0] HDR_LEN   = 6'd4;
   localparam logic [CNT_W-1:0] COST_LEN  = 6'd2;
   localparam logic [CNT_W-1:0] SEP_LEN   = 6'd1;
   localparam logic [CNT_W-1:0] SALT_LEN  = 6'd22;
   localparam logic [CNT_W-1:0] HASH_LEN  = 6'd31;
   localparam logic [CNT_W-1:0] TOTAL_LEN = 6'd60;

   localparam int COST_W     = 5;
   localparam int SALT_W     = 128;
   localparam int CTEXT_W    = 184;
   localparam int SALT_ACC_W = 132;  // 22 chars x 6 bits
   localparam int HASH_ACC_W = 186;  // 31 chars x 6 bits

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_TWO    = 8'h32;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_SLASH  = 8'h2F;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_NINE   = 8'h39;
   localparam logic [7:0] CH_UA     = 8'h41;
   localparam logic [7:0] CH_UZ     = 8'h5A;
   localparam logic [7:0] CH_LA     = 8'h61;
   localparam logic [7:0] CH_LB     = 8'h62;
   localparam logic [7:0] CH_LY     = 8'h79;
   localparam logic [7:0] CH_LZ     = 8'h7A;

endpackage

// File: rtl/split_hash_if.sv
// split_hash_if: byte-stream handshake into the hash parser.
//   in_valid : source has a byte on in_byte
//   in_byte  : ASCII character
//   in_ready : parser can take a byte this cycle
interface split_hash_if;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;

   modport master (output in_valid, output in_byte, input in_ready);
   modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/radix64_dec.sv
// radix64_dec: combinational bcrypt radix-64 character decoder.
//   ch  : ASCII character
//   val : 6-bit value ("./A-Za-z0-9" -> 0..63)
//   vld : character belongs to the alphabet
module radix64_dec
   import bcrypt_pkg::*;
(
   input  logic [7:0]       ch,
   output logic [R64_W-1:0] val,
   output logic             vld
);

   always_comb begin
      val = '0;
      vld = 1'b0;
      if (ch == CH_DOT) begin
         vld = 1'b1;
      end else if (ch == CH_SLASH) begin
         val = 6'd1;
         vld = 1'b1;
      end else if (ch >= CH_UA && ch <= CH_UZ) begin
         val = 6'(ch - CH_UA) + 6'd2;
         vld = 1'b1;
      end else if (ch >= CH_LA && ch <= CH_LZ) begin
         val = 6'(ch - CH_LA) + 6'd28;
         vld = 1'b1;
      end else if (ch >= CH_ZERO && ch <= CH_NINE) begin
         val = 6'(ch - CH_ZERO) + 6'd54;
         vld = 1'b1;
      end
   end

endmodule

// File: rtl/split_hash.sv
// split_hash: parses a 60-character bcrypt hash string into cost/salt/ctext.
//   clk, rst        : clock, asynchronous active-low reset
//   sp_en           : start pulse, honoured in IDLE/DONE/ERR
//   sif (slave)     : in_valid/in_byte/in_ready byte stream
//   cost/salt/ctext : decoded fields, nonzero only once parsing is done
//   sp_busy/done/err: status flags
// Optional macro SPLIT_HASH_TRAIL_CHECK_EN: reject nonzero discarded bits in
// the last salt character (low 4) and last hash character (low 2).
module split_hash
   import bcrypt_pkg::*;
#(
   parameter int MIN_COST = 4,
   parameter int MAX_COST = 31
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sp_en,
   split_hash_if.slave        sif,
   output logic [COST_W-1:0]  cost,
   output logic [SALT_W-1:0]  salt,
   output logic [CTEXT_W-1:0] ctext,
   output logic               sp_busy,
   output logic               sp_done,
   output logic               sp_err
);

`ifdef SPLIT_HASH_TRAIL_CHECK_EN
   localparam bit TRAIL_CHK = 1'b1;
`else
   localparam bit TRAIL_CHK = 1'b0;
`endif

   localparam logic [6:0] MIN_C = 7'(MIN_COST);
   localparam logic [6:0] MAX_C = 7'(MAX_COST);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [3:0]              tens_q, tens_d;
   logic [COST_W-1:0]       cost_q, cost_d;
   logic [SALT_ACC_W-1:0]   salt_q, salt_d;
   logic [HASH_ACC_W-1:0]   hash_q, hash_d;

   logic             busy, acc, hdr_ok, is_digit, cost_ok, rvld;
   logic [R64_W-1:0] rv;
   logic [6:0]       cost_val;

   radix64_dec u_dec (.ch(sif.in_byte), .val(rv), .vld(rvld));

   assign busy         = state_q inside {S_HDR, S_COST, S_SEP, S_SALT, S_HASH};
   assign sif.in_ready = busy;
   assign acc          = sif.in_valid && busy;
   assign sp_busy      = busy;
   assign sp_done      = (state_q == S_DONE);
   assign sp_err       = (state_q == S_ERR);

   // Accumulators keep partial data mid-parse; only a completed parse is shown.
   assign cost  = sp_done ? cost_q : '0;
   assign salt  = sp_done ? salt_q[SALT_ACC_W-1 -: SALT_W] : '0;
   assign ctext = sp_done ? hash_q[HASH_ACC_W-1 -: CTEXT_W] : '0;

   // ASCII digits carry their value in the low nibble.
   assign is_digit = (sif.in_byte >= CH_ZERO) && (sif.in_byte <= CH_NINE);
   assign cost_val = 7'(tens_q) * 7'd10 + 7'(sif.in_byte[3:0]);
   assign cost_ok  = (cost_val >= MIN_C) && (cost_val <= MAX_C);

   always_comb begin
      unique case (cnt_q)
         6'd0:    hdr_ok = (sif.in_byte == CH_DOLLAR);
         6'd1:    hdr_ok = (sif.in_byte == CH_TWO);
         6'd2:    hdr_ok = (sif.in_byte == CH_LA) || (sif.in_byte == CH_LB) ||
                           (sif.in_byte == CH_LY);
         6'd3:    hdr_ok = (sif.in_byte == CH_DOLLAR);
         default: hdr_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tens_q  <= '0;
         cost_q  <= '0;
         salt_q  <= '0;
         hash_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tens_q  <= tens_d;
         cost_q  <= cost_d;
         salt_q  <= salt_d;
         hash_q  <= hash_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tens_d  = tens_q;
      cost_d  = cost_q;
      salt_d  = salt_q;
      hash_d  = hash_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (sp_en) begin
               state_d = S_HDR;
               cnt_d   = '0;
               tens_d  = '0;
               cost_d  = '0;
               salt_d  = '0;
               hash_d  = '0;
            end
         end
         S_HDR: if (acc) begin
            if (!hdr_ok) state_d = S_ERR;
            else if (cnt_q == HDR_LEN - 6'd1) begin
               state_d = S_COST;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 6'd1;
         end
         S_COST: if (acc) begin
            if (!is_digit) state_d = S_ERR;
            else if (cnt_q == COST_LEN - 6'd1) begin
               if (!cost_ok) state_d = S_ERR;
               else begin
                  cost_d  = cost_val[COST_W-1:0];
                  state_d = S_SEP;
                  cnt_d   = '0;
               end
            end else begin
               tens_d = sif.in_byte[3:0];
               cnt_d  = cnt_q + 6'd1;
            end
         end
         S_SEP: if (acc) begin
            if (sif.in_byte != CH_DOLLAR) state_d = S_ERR;
            else if (cnt_q == SEP_LEN - 6'd1) begin
               state_d = S_SALT;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 6'd1;
         end
         S_SALT: if (acc) begin
            if (!rvld) state_d = S_ERR;
            else begin
               salt_d = {salt_q[SALT_ACC_W-R64_W-1:0], rv};
               if (cnt_q == SALT_LEN - 6'd1) begin
                  if (TRAIL_CHK && (rv[3:0] != 4'd0)) state_d = S_ERR;
                  else begin
                     state_d = S_HASH;
                     cnt_d   = '0;
                  end
               end else cnt_d = cnt_q + 6'd1;
            end
         end
         S_HASH: if (acc) begin
            if (!rvld) state_d = S_ERR;
            else begin
               hash_d = {hash_q[HASH_ACC_W-R64_W-1:0], rv};
               if (cnt_q == HASH_LEN - 6'd1) begin
                  if (TRAIL_CHK && (rv[1:0] != 2'd0)) state_d = S_ERR;
                  else begin
                     state_d = S_DONE;
                     cnt_d   = '0;
                  end
               end else cnt_d = cnt_q + 6'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_split_hash.sv
// tb_split_hash: directed scoreboard bench for split_hash.
module tb_split_hash;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sp_en = 1'b0;
   logic [4:0]   cost;
   logic [127:0] salt;
   logic [183:0] ctext;
   logic         sp_busy, sp_done, sp_err;

   split_hash_if sif();

   split_hash dut (
      .clk(clk), .rst(rst), .sp_en(sp_en), .sif(sif),
      .cost(cost), .salt(salt), .ctext(ctext),
      .sp_busy(sp_busy), .sp_done(sp_done), .sp_err(sp_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit           done;
      bit           err;
      logic [4:0]   cost;
      logic [127:0] salt;
      logic [183:0] ctext;
      int           nacc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic string rep(input byte c, input int n);
      string r = "";
      for (int i = 0; i < n; i++) r = $sformatf("%s%c", r, c);
      return r;
   endfunction

   function automatic logic [5:0] dec(input byte c);
      if (c == ".") return 6'd0;
      if (c == "/") return 6'd1;
      if (c >= "A" && c <= "Z") return 6'(c - "A" + 2);
      if (c >= "a" && c <= "z") return 6'(c - "a" + 28);
      return 6'(c - "0" + 54);
   endfunction

   function automatic exp_t mk_ok(input string s);
      exp_t e;
      logic [131:0] sa = '0;
      logic [185:0] ha = '0;
      for (int i = 0; i < 22; i++) sa = {sa[125:0], dec(s[7+i])};
      for (int i = 0; i < 31; i++) ha = {ha[179:0], dec(s[29+i])};
      e.done  = 1'b1;
      e.err   = 1'b0;
      e.cost  = 5'((s[4] - "0") * 10 + (s[5] - "0"));
      e.salt  = sa[131:4];
      e.ctext = ha[185:2];
      e.nacc  = 60;
      return e;
   endfunction

   function automatic exp_t mk_err(input int n);
      exp_t e;
      e.done = 1'b0; e.err = 1'b1; e.cost = '0; e.salt = '0; e.ctext = '0; e.nacc = n;
      return e;
   endfunction

   task automatic start();
      sp_en = 1'b1;
      @(posedge clk); #1;
      sp_en = 1'b0;
      chk("start_busy", sp_busy, 1);
      chk("start_done_clr", sp_done, 0);
      chk("start_cost_clr", cost, 0);
   endtask

   // Drives bytes one handshake at a time; stops on done/err, max_acc or budget.
   task automatic feed(input string s, input bit rnd, input int en_at,
                       input int max_acc, output int nacc);
      int   idx = 0;
      int   cyc = 0;
      logic rdy;
      while (idx < s.len() && idx < max_acc && cyc < 3000) begin
         if (sp_done || sp_err) break;
         sif.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         sif.in_byte  = s[idx];
         sp_en        = (idx == en_at);
         rdy          = sif.in_ready;
         @(posedge clk); #1;
         if (sif.in_valid && rdy) idx++;
         cyc++;
      end
      sp_en        = 1'b0;
      sif.in_valid = 1'b0;
      nacc         = idx;
   endtask

   task automatic run(input string tag, input string s, input exp_t e,
                      input bit rnd, input int en_at);
      int   nacc;
      int   cyc = 0;
      exp_t x;
      start();
      sb.push_back(e);
      feed(s, rnd, en_at, 60, nacc);
      while (!(sp_done || sp_err) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_finished"}, sp_done | sp_err, 1);
      x = sb.pop_front();
      chk({tag, "_done"}, sp_done, x.done);
      chk({tag, "_err"}, sp_err, x.err);
      chk({tag, "_cost"}, cost, x.cost);
      chk({tag, "_salt"}, salt, x.salt);
      chk({tag, "_ctext"}, ctext, x.ctext);
      chk({tag, "_nacc"}, nacc, x.nacc);
      chk({tag, "_ready"}, sif.in_ready, 0);
      chk({tag, "_busy"}, sp_busy, 0);
      @(posedge clk); #1;
      chk({tag, "_hold"}, {sp_done, sp_err}, {x.done, x.err});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s1, s9, bh, c03, c3a, c32, mix, bad;
      int    nacc;

      s1  = {"$2b$12$", rep(".", 53)};
      s9  = {"$2y$31$", rep("9", 53)};
      bh  = {"$2x$12$", rep(".", 53)};
      c03 = {"$2b$03$", rep(".", 53)};
      c3a = {"$2b$3a$", rep(".", 53)};
      c32 = {"$2b$32$", rep(".", 53)};
      mix = {"$2a$04$", "ABCDEFGHIJKLMNOPQRSTU.", "abcdefghijklmnopqrstuvwxyz0123."};
      bad = {"$2a$04$", "!", rep(".", 52)};

      sif.in_valid = 1'b1;
      sif.in_byte  = "$";
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", sif.in_ready, 0);
      chk("rst_flags", {sp_busy, sp_done, sp_err}, 0);
      chk("rst_outs", {cost, salt, ctext}, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_no_accept", {sif.in_ready, sp_busy}, 0);
      sif.in_valid = 1'b0;

      run("basic", s1, mk_ok(s1), 1'b0, -1);
      // Explicit all-zero expectation on top of the model
      chk("basic_cost12", cost, 12);
      chk("basic_salt0", salt, 0);

`ifdef SPLIT_HASH_TRAIL_CHECK_EN
      run("nines", s9, mk_err(29), 1'b0, -1);
`else
      run("nines", s9, mk_ok(s9), 1'b0, -1);
      chk("nines_salt_ones", salt, {128{1'b1}});
      chk("nines_ctext_ones", ctext, {184{1'b1}});
`endif

      run("hdr_x", bh, mk_err(3), 1'b0, -1);
      run("restart", s1, mk_ok(s1), 1'b0, 59);    // sp_en with final byte is ignored
      run("cost03", c03, mk_err(6), 1'b0, -1);
      run("cost3a", c3a, mk_err(6), 1'b0, -1);
      run("cost32", c32, mk_err(6), 1'b0, -1);
      run("mix", mix, mk_ok(mix), 1'b0, 20);      // sp_en mid-parse is ignored
      run("badchar", bad, mk_err(8), 1'b0, -1);
      run("rnd_valid", s1, mk_ok(s1), 1'b1, -1);

      // Reset asserted mid-salt
      start();
      feed(s1, 1'b0, -1, 17, nacc);
      chk("mid_nacc", nacc, 17);
      chk("mid_busy", sp_busy, 1);
      sif.in_valid = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_flags", {sp_busy, sp_done, sp_err, sif.in_ready}, 0);
      chk("mid_rst_outs", {cost, salt, ctext}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", {sif.in_ready, sp_busy, sp_done, sp_err}, 0);
      sif.in_valid = 1'b0;
      run("after_rst", mix, mk_ok(mix), 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/split_hash.md
SPLIT_HASH -- requirements
Module: split_hash

Interface
REQ-001 SHALL have parameter MIN_COST, default 4, meaning the lowest legal cost value.
REQ-002 SHALL have parameter MAX_COST, default 31, meaning the highest legal cost value.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port sp_en, input, 1, a start pulse that is honoured only in IDLE, DONE or ERR.
REQ-006 SHALL have ports in_valid (input, 1), in_byte (input, 8) and in_ready (output, 1), an ASCII byte stream of the 60-character hash string.
REQ-007 SHALL have output ports cost (5), salt (128) and ctext (184), the decoded fields.
REQ-008 SHALL have output ports sp_busy, sp_done and sp_err (1 bit each), the status flags.

Function
REQ-009 SHALL accept a byte only when in_valid and in_ready are both high in the same cycle; in_ready is high exactly in the states HDR, COST, SEP, SALT and HASH.
REQ-010 SHALL use the states IDLE, HDR, COST, SEP, SALT, HASH, DONE and ERR; sp_en moves IDLE, DONE or ERR to HDR and clears the outputs and flags.
REQ-011 SHALL, in HDR, accept exactly 4 bytes: '$', '2', a version byte in {'a','b','y'}, and '$'; any mismatch goes to ERR.
REQ-012 SHALL, in COST, accept 2 ASCII decimal digits (tens digit first); a non-digit, or a value outside MIN_COST..MAX_COST, goes to ERR.
REQ-013 SHALL, in SEP, accept 1 byte that must be '$'.
REQ-014 SHALL decode SALT (22 chars) and HASH (31 chars) with the bcrypt radix-64 alphabet "./A-Za-z0-9": '.'=0, '/'=1, 'A'=2, 'Z'=27, 'a'=28, 'z'=53, '0'=54, '9'=63; any character outside the alphabet goes to ERR.
REQ-015 SHALL shift the 6-bit values in MSB-first order: salt = the upper 128 of the 132 accumulated bits, ctext = the upper 184 of the 186 accumulated bits.
REQ-016 SHALL track its position with a 6-bit byte counter that resets per state; the state advances on the acceptance of the last byte of the field.
REQ-017 SHALL assert sp_done in the cycle after the 60th byte is accepted, and hold it and the outputs until sp_en or reset.
REQ-018 SHALL assert sp_err in the cycle after the offending byte is accepted, drop in_ready, and hold the outputs at zero.
REQ-019 SHALL keep sp_busy high in the states HDR through HASH.
REQ-020 SHALL ignore sp_en while busy and SHALL ignore in_valid while in_ready is low.
REQ-021 SHALL treat sp_en arriving in the same cycle as the final byte of a previous run as having no effect; the flags are only visible afterwards.

Reset
REQ-022 SHALL, while rst is low, immediately force state IDLE, the counters to 0, cost/salt/ctext to 0, and all flags and in_ready to 0, including when a parse is in progress.
REQ-023 SHALL leave reset without requiring in_valid to be low; no byte is accepted until sp_en is given.

Configuration
REQ-024 SHALL provide macro SPLIT_HASH_TRAIL_CHECK_EN; when it is defined, nonzero discarded bits (the low 4 bits of salt char 22, the low 2 bits of hash char 31) go to ERR.
REQ-025 SHALL, without SPLIT_HASH_TRAIL_CHECK_EN, silently drop the discarded bits.

Structure
REQ-026 SHALL put the state enum, the field lengths (4/2/1/22/31/60), the ASCII constants and the bit widths in the shared package bcrypt_pkg.
REQ-027 SHALL put the character decode in one combinational sub-module, radix64_dec: input 8-bit char; outputs 6-bit value and a valid flag.

Verification
REQ-028 SHALL test "$2b$12$" + 22x'.' + 31x'.' with in_valid held high: in_ready is high for 60 cycles, then sp_done=1, cost=12, salt=0, ctext=0, sp_err=0.
REQ-029 SHALL test "$2y$31$" + 22x'9' + 31x'9' with the macro off: cost=31, salt=all ones, ctext=all ones; with the macro on, sp_err=1 after char 22 of the salt.
REQ-030 SHALL test the header "$2x$": sp_err=1 the cycle after byte 3, in_ready=0, and outputs 0; a following sp_en restarts parsing cleanly.
REQ-031 SHALL test cost "03" and "3a": each gives sp_err=1 after the second cost digit.
REQ-032 SHALL test in_valid toggled randomly during a valid string: the result matches REQ-028 and the byte count is exact.
REQ-033 SHALL test rst pulled low at salt char 10: all outputs are 0 immediately, and after release the state is IDLE with in_ready=0.
